// File: rtl/display_scan_7seg_pkg.sv
// rtl/display_scan_7seg_pkg.sv - shared types and BCD segment decode for the display blocks
package display_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h00;
  localparam seg_t SEG_DASH  = 7'h40;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // Active-high pattern, bit0 = a ... bit6 = g; non-BCD codes show a dash.
  function automatic seg_t bcd_to_seg(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/display_scan_7seg_if.sv
// rtl/display_scan_7seg_if.sv - strobe, digit data and pin-side signals of the 7-segment scanner
interface display_scan_7seg_if #(
  parameter int NUM_DIGITS = 6,
  parameter int IDX_W      = $clog2(NUM_DIGITS)
);
  logic                    enable7segmentos;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    blank_lead;
  logic [6:0]              segments;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   anodes;
  logic [IDX_W-1:0]        digit_idx;
  logic                    frame_done;

  modport master (
    output enable7segmentos, digits, blink_mask, dp_mask, blank_lead,
    input  segments, dp, anodes, digit_idx, frame_done
  );

  modport slave (
    input  enable7segmentos, digits, blink_mask, dp_mask, blank_lead,
    output segments, dp, anodes, digit_idx, frame_done
  );
endinterface

// File: rtl/display_scan_7seg_bcd_to_7seg.sv
// rtl/display_scan_7seg_bcd_to_7seg.sv - combinational BCD to active-high 7-segment decoder
module bcd_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output seg_t       seg
);
  assign seg = bcd_to_seg(bcd);
endmodule

// File: rtl/display_scan_7seg.sv
// rtl/display_scan_7seg.sv - strobe-driven digit multiplexer with ghost blanking, blink and lead-zero suppression
module display_scan_7seg
  import display_pkg::*;
#(
  parameter int NUM_DIGITS     = 6,
  parameter int ACTIVE_LOW_SEG = 1,
  parameter int ACTIVE_LOW_AN  = 1,
  parameter int BLINK_FRAMES   = 64
) (
  input logic                clk,
  input logic                reset,
  display_scan_7seg_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  typedef logic [IDX_W-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  localparam seg_t                  SEG_POL = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_POL  = (ACTIVE_LOW_SEG != 0);
  localparam logic [NUM_DIGITS-1:0] AN_POL  = (ACTIVE_LOW_AN != 0) ? '1 : '0;

  scan_state_t           state, state_nx;
  idx_t                  idx, idx_nx;
  logic                  wrapped, wrapped_nx;
  logic [CNT_W-1:0]      frame_cnt, frame_cnt_nx;
  logic                  phase, phase_nx;
  logic                  frame_tick;

  logic [3:0]            nib;
  logic                  blink_bit, dp_bit, blink_off, lead_off, dp_on;
  logic [NUM_DIGITS-1:0] onehot;
  seg_t                  dec_seg, pattern;

  seg_t                  seg_q, seg_nx;
  logic                  dp_q, dp_nx, fd_q, fd_nx;
  logic [NUM_DIGITS-1:0] an_q, an_nx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= BLANK;
      idx       <= '0;
      wrapped   <= 1'b0;
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      wrapped   <= wrapped_nx;
      frame_cnt <= frame_cnt_nx;
      phase     <= phase_nx;
    end
  end

  // wrapped marks that the coming BLANK->DRIVE edge starts a new frame (not the post-reset entry)
  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    wrapped_nx = wrapped;
    case (state)
      BLANK: begin
        state_nx   = DRIVE;
        wrapped_nx = 1'b0;
      end
      DRIVE: begin
        if (bus.enable7segmentos) begin
          state_nx = BLANK;
          if (idx == LAST_IDX) begin
            idx_nx     = '0;
            wrapped_nx = 1'b1;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      default: state_nx = BLANK;
    endcase
  end

  assign frame_tick = (state == BLANK) && wrapped;

  always_comb begin
    frame_cnt_nx = frame_cnt;
    phase_nx     = phase;
    if (frame_tick) begin
      if (frame_cnt == CNT_LAST) begin
        frame_cnt_nx = '0;
        phase_nx     = ~phase;
      end else begin
        frame_cnt_nx = frame_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    nib       = '0;
    blink_bit = 1'b0;
    dp_bit    = 1'b0;
    onehot    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == idx_t'(i)) begin
        nib       = bus.digits[4*i +: 4];
        blink_bit = bus.blink_mask[i];
        dp_bit    = bus.dp_mask[i];
        onehot[i] = 1'b1;
      end
    end
  end

  bcd_to_7seg u_dec (
    .bcd (nib),
    .seg (dec_seg)
  );

  // phase_nx so the first digit of a toggling frame already sees the new phase
  assign blink_off = blink_bit & phase_nx;
  assign lead_off  = bus.blank_lead && (idx == LAST_IDX) && (nib == 4'd0);
  assign pattern   = (blink_off || lead_off) ? SEG_BLANK : dec_seg;
  assign dp_on     = dp_bit & ~blink_off;

  always_comb begin
    seg_nx = SEG_BLANK ^ SEG_POL;
    dp_nx  = DP_POL;
    an_nx  = AN_POL;
    fd_nx  = 1'b0;
    if (state == BLANK) begin
      seg_nx = pattern ^ SEG_POL;
      dp_nx  = dp_on ^ DP_POL;
      an_nx  = onehot ^ AN_POL;
      fd_nx  = frame_tick;
    end else if (!bus.enable7segmentos) begin
      seg_nx = seg_q;
      dp_nx  = dp_q;
      an_nx  = an_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_q <= SEG_BLANK ^ SEG_POL;
      dp_q  <= DP_POL;
      an_q  <= AN_POL;
      fd_q  <= 1'b0;
    end else begin
      seg_q <= seg_nx;
      dp_q  <= dp_nx;
      an_q  <= an_nx;
      fd_q  <= fd_nx;
    end
  end

  assign bus.segments   = seg_q;
  assign bus.dp         = dp_q;
  assign bus.anodes     = an_q;
  assign bus.frame_done = fd_q;
  assign bus.digit_idx  = idx;

endmodule
